// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if
//   Bundles the request/response handshake between the execute stage and the
//   load/store unit, together with the word-memory strobes the unit drives.
//
//   Request  : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata
//   Response : resp_valid, resp_rdata, resp_err
//   Memory   : mem_addrs, mem_read, mem_write, write_data, read_data
//
//   modport master : the load/store unit (drives ready/response/memory strobes)
//   modport slave  : the surrounding system (drives requests and read data)
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addrs;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addrs, mem_read, mem_write, write_data
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addrs, mem_read, mem_write, write_data
  );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator between the execute stage and a single-port word
//   memory (10-bit word address, combinational read, synchronous write).
//   Accepts one byte/half/word access at a time, performs read-modify-write
//   for SB/SH, and returns sign/zero-extended load data with a one-cycle
//   response pulse.
//
//   Ports:
//     clk   : sole clock, rising edge
//     rst_n : synchronous, active-low reset
//     bus   : lsu_mem_master_if.master (request, response and memory strobes)
//
//   Optional feature:
//     LSU_BOUNDS_CHECK_EN : when defined, any req_addr[31:12] != 0 is an
//                           error; otherwise addresses alias modulo 4 KiB.
module lsu_mem_master (
  input logic              clk,
  input logic              rst_n,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg, state_next;

  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  addr_lo_reg;
  logic [15:0] wdata_reg;        // only the low half is ever merged
  logic [9:0]  mem_addrs_reg;
  logic [31:0] write_data_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic        accept;
  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        req_is_sw;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // ---------------------------------------------------------------------------
  // Request decode (evaluated on the live request in IDLE)
  // ---------------------------------------------------------------------------
  assign accept = bus.req_valid && (state_reg == IDLE);

  always_comb begin
    funct3_ok = 1'b0;
    if (bus.req_we) begin
      funct3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
        default:                                funct3_ok = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes size for every legal code; illegal codes are already
  // flagged, so their alignment result does not matter.
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = (bus.req_addr[31:12] != 20'd0);
`else
  // Upper address bits alias onto the 4 KiB window.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:12];
  assign out_of_range   = 1'b0;
`endif

  assign req_err   = !funct3_ok || misaligned || out_of_range;
  assign req_is_sw = bus.req_we && (bus.req_funct3 == 3'b010);

  // ---------------------------------------------------------------------------
  // Load extraction from the word presented during READ
  // ---------------------------------------------------------------------------
  assign load_byte = bus.read_data[{addr_lo_reg, 3'b000} +: 8];
  assign load_half = bus.read_data[{addr_lo_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext = {24'd0, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b101:  load_ext = {16'd0, load_half};
      default: load_ext = bus.read_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sub-word store merge: each byte lane takes new data when it is selected
  // by the byte (SB) or half (SH) lane of the address, else keeps memory data.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_en;
      logic [7:0] lane_src;

      assign lane_en  = (funct3_reg[1:0] == 2'b00) ? (addr_lo_reg == LANE)
                                                   : (addr_lo_reg[1] == LANE[1]);
      assign lane_src = (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0]
                                                   : wdata_reg[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = lane_en ? lane_src : bus.read_data[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    bus.req_ready  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_err)        state_next = RESP;
          else if (req_is_sw) state_next = WRITE;
          else                state_next = READ;
        end
      end
      READ: begin
        bus.mem_read = 1'b1;
        state_next   = we_reg ? WRITE : RESP;
      end
      WRITE: begin
        // Gated by reset so an abort never commits a write at the reset edge.
        bus.mem_write = rst_n;
        state_next    = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_reg         <= 1'b0;
      funct3_reg     <= 3'd0;
      addr_lo_reg    <= 2'd0;
      wdata_reg      <= 16'd0;
      mem_addrs_reg  <= 10'd0;
      write_data_reg <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg        <= bus.req_we;
            funct3_reg    <= bus.req_funct3;
            addr_lo_reg   <= bus.req_addr[1:0];
            wdata_reg     <= bus.req_wdata[15:0];
            mem_addrs_reg <= bus.req_addr[11:2];
            if (req_err) begin
              resp_rdata_reg <= 32'd0;
              resp_err_reg   <= 1'b1;
            end else if (req_is_sw) begin
              write_data_reg <= bus.req_wdata;
            end
          end
        end
        READ: begin
          if (we_reg) begin
            write_data_reg <= merged;
          end else begin
            resp_rdata_reg <= load_ext;
            resp_err_reg   <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata_reg <= 32'd0;
          resp_err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addrs  = mem_addrs_reg;
  assign bus.write_data = write_data_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master
//   Directed stimulus with hand-computed expectations pushed into a scoreboard
//   queue; a negedge monitor checks memory strobes and pops/compares each
//   response (data, error, latency, number of reads/writes).
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if bus ();

  lsu_mem_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Word memory model with a preload port used during reset.
  logic [31:0] mem [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus.read_data = bus.mem_read ? mem[bus.mem_addrs] : 32'd0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_write) mem[bus.mem_addrs] <= bus.write_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [9:0]  maddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   ncyc = 0;
  int   acc_neg = 0;
  int   reads = 0;
  int   writes = 0;
  int   overlap = 0;
  int   resp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n) begin
      if (bus.mem_read && bus.mem_write) overlap++;
      if (bus.mem_read) begin
        reads++;
        if (sb_q.size() > 0) chk("rd_addr", 32'(bus.mem_addrs), 32'(sb_q[0].maddr));
      end
      if (bus.mem_write) begin
        writes++;
        if (sb_q.size() > 0) begin
          chk("wr_addr", 32'(bus.mem_addrs), 32'(sb_q[0].maddr));
          chk("wr_data", bus.write_data, sb_q[0].wdata);
        end
      end
      if (bus.resp_valid) begin
        resp_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(e.err));
          chk("latency", 32'(ncyc - acc_neg), 32'(e.lat));
          chk("num_reads", 32'(reads), 32'(e.rd));
          chk("num_writes", 32'(writes), 32'(e.wr));
          chk("rw_exclusive", 32'(overlap), 32'd0);
          $display("resp: rdata=%h err=%0d lat=%0d", bus.resp_rdata, bus.resp_err, ncyc - acc_neg);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_neg = ncyc;
        reads   = 0;
        writes  = 0;
        overlap = 0;
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input int lat, input int rd, input int wr,
                       input logic [9:0] maddr, input logic [31:0] ewd);
    exp_t e;
    e.rdata = erd; e.err = eerr; e.lat = lat; e.rd = rd; e.wr = wr;
    e.maddr = maddr; e.wdata = ewd;
    sb_q.push_back(e);
    $display("req: we=%0d f3=%b addr=%h wdata=%h", we, f3, addr, wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      chk("resp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    #1;
  endtask

  initial begin
    int rc;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    @(posedge clk);
    #1;
    preload(10'd0, 32'h01020304);
    preload(10'd2, 32'h8899AABB);
    preload(10'd4, 32'h11223344);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_addrs", 32'(bus.mem_addrs), 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    @(posedge clk);
    #1;

    //     we    f3      addr          wdata          exp_rdata      err  lat rd wr maddr  exp_wdata
    issue(1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'h8899AABB, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b0, 3'b000, 32'h0000_000B, 32'h0,         32'hFFFFFF88, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b0, 3'b100, 32'h0000_000B, 32'h0,         32'h00000088, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b0, 3'b001, 32'h0000_000A, 32'h0,         32'hFFFF8899, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b0, 3'b101, 32'h0000_0008, 32'h0,         32'h0000AABB, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b0, 3'b000, 32'h0000_0008, 32'h0,         32'hFFFFFFBB, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b1, 3'b000, 32'h0000_0009, 32'h0000005A,  32'h0,        1'b0, 3, 1, 1, 10'd2, 32'h88995ABB);
    issue(1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'h88995ABB, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_0003, 32'h00001234,  32'h0,        1'b1, 1, 0, 0, 10'd0, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,        1'b1, 1, 0, 0, 10'd1, 32'h0);
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        1'b1, 1, 0, 0, 10'd0, 32'h0);
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,        1'b1, 1, 0, 0, 10'd0, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_000A, 32'h0000CAFE,  32'h0,        1'b0, 3, 1, 1, 10'd2, 32'hCAFE5ABB);
    issue(1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hCAFE5ABB, 1'b0, 2, 1, 0, 10'd2, 32'h0);
    issue(1'b1, 3'b010, 32'h0000_000C, 32'h12345678,  32'h0,        1'b0, 2, 0, 1, 10'd3, 32'h12345678);
    issue(1'b0, 3'b101, 32'h0000_000E, 32'h0,         32'h00001234, 1'b0, 2, 1, 0, 10'd3, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'h0,        1'b1, 1, 0, 0, 10'd0, 32'h0);
`else
    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'h01020304, 1'b0, 2, 1, 0, 10'd0, 32'h0);
`endif

    // Store word aborted by reset while in WRITE.
    rc = resp_count;
    $display("req: we=1 f3=010 addr=00000010 wdata=deadbeef (reset during WRITE)");
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0010;
    bus.req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("write_gated_by_reset", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
    chk("no_resp_on_abort", 32'(resp_count), 32'(rc));
    @(posedge clk);
    #1;
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h11223344, 1'b0, 2, 1, 0, 10'd4, 32'h0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator between the RISC-V execute stage and the single-port word memory (10-bit word address, combinational read gated by `mem_read`, write on rising `clk` when `mem_write` is high). It accepts one byte/half/word load or store request at a time and sequences the memory strobes. It performs read-modify-write for sub-word stores, then returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
Parameters: none.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle; the request is accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (size/sign).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, illegal funct3, or out of range; qualified by `resp_valid`.
- `mem_addrs` out 10: word address, `addr_q[11:2]`.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `write_data` out 32: merged word to write.
- `read_data` in 32: memory read data; valid in the same cycle as `mem_read`.

## Operation
- FSM has four states: IDLE, READ, WRITE, RESP. `req_ready` = (state == IDLE).
- IDLE, on acceptance: latch addr/we/funct3/wdata.
  - Error → RESP with `resp_err` = 1 and no memory access.
  - Load or SB/SH → READ.
  - SW → WRITE with `write_data` = `req_wdata`.
- READ: `mem_read` = 1. Capture `read_data` at the edge.
  - Load → RESP.
  - SB/SH → WRITE with merged word:
    - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
    - SH replaces half lane `addr[1]` with `wdata[15:0]`.
- WRITE: `mem_write` = 1 for exactly one cycle → RESP.
- RESP: `resp_valid` = 1 → IDLE.
- Load extraction from the captured word:
  - LB (000) / LBU (100): byte lane `addr[1:0]`, sign- or zero-extended.
  - LH (001) / LHU (101): half lane `addr[1]`, sign- or zero-extended.
  - LW (010): full word.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else sets `resp_err`.
- Misaligned cases set `resp_err`:
  - Halfword with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
- `resp_rdata` and `resp_err` update only on entry to RESP and hold until the next RESP.
- `mem_read` and `mem_write` are never both high. Both are low in IDLE and RESP.

## Timing
- Cycles from the acceptance edge to `resp_valid` high:
  - Error: 1.
  - Load or SW: 2.
  - SB/SH: 3.
- Throughput: `req_ready` rises in the cycle after RESP, so there is no back-to-back overlap.
- `mem_addrs` and `write_data` are registered and stable for the whole READ/WRITE cycle.
- Reset values:
  - State = IDLE; `req_ready` = 1 after the first reset edge.
  - `resp_valid`, `resp_err`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_addrs`, `write_data` = 0.
- `req_valid` is ignored while `rst_n` is low.
- Reset mid-operation:
  - The transaction is aborted with no response.
  - `mem_write` is gated by `rst_n`, so no write reaches memory at an edge where `rst_n` is low, even in WRITE.
  - An RMW interrupted after READ leaves memory unmodified.

## Configuration
- Macro: `LSU_BOUNDS_CHECK_EN`.
- Defined: `req_addr[31:12]` ≠ 0 sets `resp_err` with 1-cycle latency and no memory access.
- Undefined: `req_addr[31:12]` is ignored and addresses alias modulo 4 KiB.

## Test plan
- LW at 0x008 with memory word 2 = 0x8899AABB → `mem_read` for one cycle on `mem_addrs` = 2; `resp_valid` 2 cycles after acceptance with `resp_rdata` = 0x8899AABB and `resp_err` = 0.
- LB / LBU at 0x00B, same word → `resp_rdata` = 0xFFFFFF88 / 0x00000088. LH at 0x00A → 0xFFFF8899.
- SB of 0x5A at 0x009 with word 2 = 0x8899AABB → READ, then WRITE with `write_data` = 0x88995ABB; a following LW returns 0x88995ABB; `resp_valid` arrives 3 cycles after acceptance.
- SH at 0x003 or LW at 0x006 → `resp_err` = 1 after 1 cycle; `mem_read` and `mem_write` stay 0.
- SW of 0xDEADBEEF at 0x010, with `rst_n` pulled low during the WRITE cycle → memory word 4 unchanged, no `resp_valid`, `req_ready` = 1 after release.
- LW at 0x00001000: with `LSU_BOUNDS_CHECK_EN` → `resp_err` = 1; without it → reads word 0.
